// File: rtl/jpeg_uart_pkg.sv
// Shared types and constants for the JPEG <-> UART byte bridge.
package jpeg_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_WORD = 2'd1,
    SEND_LB   = 2'd2
  } ser_state_t;

  localparam int LED_OVF  = 0;
  localparam int LED_FULL = 1;
  localparam int LED_BUSY = 2;
  localparam int LED_LB   = 3;

  function automatic int bytes_per_word(input int dout_w);
    return dout_w / 8;
  endfunction

endpackage

// File: rtl/jpeg_uart_bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop in the same cycle
// are legal even when full (the caller only pushes into a full FIFO while popping).
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; dout is only consumed on a pop of a valid entry.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/jpeg_uart_bridge.sv
// UART <-> JPEG core bridge: RX bytes feed the core (or loop back to TX),
// core output words are buffered and serialized to the UART a byte at a time.
module jpeg_uart_bridge
  import jpeg_uart_pkg::*;
#(
  parameter  int DOUT_W     = 32,
  parameter  int FIFO_DEPTH = 64,
  parameter  bit MSB_FIRST  = 1'b1,
  parameter  int CNT_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loopback,
  input  logic              clear_status,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        core_din,
  output logic              core_din_valid,
  input  logic [DOUT_W-1:0] core_dout,
  input  logic              core_dout_valid,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [CNT_W-1:0]  drop_count,
  output logic [3:0]        led
);

  localparam int BPW = bytes_per_word(DOUT_W);
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

  ser_state_t        state, state_nx;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [DOUT_W-1:0] fifo_dout;
  logic [DOUT_W-1:0] sreg, sreg_shift;
  logic [7:0]        word_byte;
  logic [BIW-1:0]    byte_idx;
  logic              last_byte;
  logic [7:0]        lb_byte;
  logic              lb_valid, lb_in, lb_pop, lb_drop;
  logic              ovf_q, full_q, lb_mode_q;
  logic [1:0]        n_drop;
  logic [CNT_W:0]    drop_sum;

  // ---------------- input path ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      core_din       <= '0;
      core_din_valid <= 1'b0;
      lb_mode_q      <= 1'b0;
    end else begin
      core_din       <= rx_data;
      core_din_valid <= rx_valid & ~loopback;
      lb_mode_q      <= loopback;
    end
  end

  // ---------------- word FIFO ----------------
  // A full FIFO still takes a word when the serializer pops in the same cycle.
  assign fifo_push = core_dout_valid & (~fifo_full | fifo_pop);
  assign fifo_drop = core_dout_valid & ~fifo_push;

  sync_fifo #(
    .WIDTH (DOUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (core_dout),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ---------------- loopback byte register ----------------
  assign lb_in   = loopback & rx_valid;
  assign lb_pop  = (state == SEND_LB) & tx_ready;
  assign lb_drop = lb_in & lb_valid & ~lb_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      lb_byte  <= '0;
      lb_valid <= 1'b0;
    end else if (lb_in && !lb_drop) begin
      lb_byte  <= rx_data;
      lb_valid <= 1'b1;
    end else if (lb_pop) begin
      lb_valid <= 1'b0;
    end
  end

  // ---------------- serializer ----------------
  if (MSB_FIRST) begin : g_msb
    assign word_byte  = sreg[DOUT_W-1 -: 8];
    assign sreg_shift = sreg << 8;
  end else begin : g_lsb
    assign word_byte  = sreg[7:0];
    assign sreg_shift = sreg >> 8;
  end

  assign last_byte = (byte_idx == BIW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Loopback bytes wait for the current word stream to drain; a pending lb byte
  // only wins over queued words when the serializer is back in IDLE.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (lb_valid) begin
          state_nx = SEND_LB;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = SEND_WORD;
        end
      end
      SEND_WORD: begin
        if (tx_ready && last_byte) begin
          if (!fifo_empty) fifo_pop = 1'b1;
          else             state_nx = IDLE;
        end
      end
      SEND_LB: begin
        if (tx_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      byte_idx <= '0;
    end else if (fifo_pop) begin
      sreg     <= fifo_dout;
      byte_idx <= '0;
    end else if (state == SEND_WORD && tx_ready) begin
      sreg     <= sreg_shift;
      byte_idx <= byte_idx + BIW'(1);
    end
  end

  assign tx_valid = (state == SEND_WORD) || (state == SEND_LB);

  always_comb begin
    tx_data = 8'h00;
    if (state == SEND_WORD)    tx_data = word_byte;
    else if (state == SEND_LB) tx_data = lb_byte;
  end

  // ---------------- status ----------------
  assign n_drop   = {1'b0, fifo_drop} + {1'b0, lb_drop};
  assign drop_sum = {1'b0, drop_count} + (CNT_W+1)'(n_drop);

  // A drop or full event in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      full_q     <= 1'b0;
      drop_count <= '0;
    end else begin
      ovf_q  <= (ovf_q  & ~clear_status) | fifo_drop | lb_drop;
      full_q <= (full_q & ~clear_status) | fifo_full;
      if (clear_status)      drop_count <= CNT_W'(n_drop);
      else if (drop_sum[CNT_W]) drop_count <= '1;
      else                   drop_count <= drop_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    led           = '0;
    led[LED_OVF]  = ovf_q;
    led[LED_FULL] = full_q;
    led[LED_BUSY] = tx_valid;
    led[LED_LB]   = lb_mode_q;
  end

endmodule

// File: tb/tb_jpeg_uart_bridge.sv
// Bench for jpeg_uart_bridge: MSB-first and LSB-first instances share stimulus;
// directed vectors/sequences plus random traffic against a queue-based model.
module tb_jpeg_uart_bridge;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int BPW   = DW / 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk, rst, loopback, clear_status, rx_valid, core_dout_valid, tx_ready;
  logic [7:0]    rx_data;
  logic [DW-1:0] core_dout;

  logic [7:0]    a_din, b_din, a_txd, b_txd;
  logic          a_dinv, b_dinv, a_txv, b_txv;
  logic [LW-1:0] a_lvl, b_lvl;
  logic [CW-1:0] a_cnt, b_cnt;
  logic [3:0]    a_led, b_led;

  jpeg_uart_bridge #(.DOUT_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .loopback(loopback), .clear_status(clear_status),
    .rx_valid(rx_valid), .rx_data(rx_data), .core_din(a_din), .core_din_valid(a_dinv),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .tx_valid(a_txv), .tx_data(a_txd), .tx_ready(tx_ready),
    .fifo_level(a_lvl), .drop_count(a_cnt), .led(a_led));

  jpeg_uart_bridge #(.DOUT_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .loopback(loopback), .clear_status(clear_status),
    .rx_valid(rx_valid), .rx_data(rx_data), .core_din(b_din), .core_din_valid(b_dinv),
    .core_dout(core_dout), .core_dout_valid(core_dout_valid),
    .tx_valid(b_txv), .tx_data(b_txd), .tx_ready(tx_ready),
    .fifo_level(b_lvl), .drop_count(b_cnt), .led(b_led));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] got[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model (queues, byte counts) ----------------
  logic [DW-1:0] r_q[$];
  logic [DW-1:0] r_word;
  int            r_left;     // bytes of r_word still to be sent
  bit            r_lbsend, r_lbv, r_ovf, r_full, r_lbmode, r_cdv;
  logic [7:0]    r_lb, r_cd;
  int            r_cnt;

  task automatic model_step();
    bit popped, lpop, was_full, fdrop, ldrop, li;
    int nd;
    if (rst) begin
      r_q.delete(); r_word = '0; r_left = 0; r_lbsend = 0; r_lbv = 0; r_lb = '0;
      r_ovf = 0; r_full = 0; r_lbmode = 0; r_cdv = 0; r_cd = '0; r_cnt = 0;
      return;
    end
    was_full = (r_q.size() == DEPTH);
    popped = 0; lpop = 0;
    if (r_left > 0) begin
      if (tx_ready) begin
        r_left--;
        if (r_left == 0 && r_q.size() > 0) begin
          r_word = r_q.pop_front(); r_left = BPW; popped = 1;
        end
      end
    end else if (r_lbsend) begin
      if (tx_ready) begin r_lbsend = 0; lpop = 1; end
    end else if (r_lbv) begin
      r_lbsend = 1;
    end else if (r_q.size() > 0) begin
      r_word = r_q.pop_front(); r_left = BPW; popped = 1;
    end
    fdrop = core_dout_valid && was_full && !popped;
    if (core_dout_valid && !fdrop) r_q.push_back(core_dout);
    li = loopback && rx_valid;
    ldrop = li && r_lbv && !lpop;
    if (li && !ldrop) begin r_lb = rx_data; r_lbv = 1; end
    else if (lpop) r_lbv = 0;
    nd = int'(fdrop) + int'(ldrop);
    if (clear_status) r_cnt = nd;
    else r_cnt = (r_cnt + nd > CMAX) ? CMAX : r_cnt + nd;
    r_ovf = (r_ovf && !clear_status) || fdrop || ldrop;
    r_full = (r_full && !clear_status) || was_full;
    r_lbmode = loopback;
    r_cd = rx_data;
    r_cdv = rx_valid && !loopback;
  endtask

  task automatic check_model();
    bit txv;
    logic [7:0] em, el;
    txv = (r_left > 0) || r_lbsend;
    chk("model core_din a", a_din, r_cd);
    chk("model core_din b", b_din, r_cd);
    chk("model core_din_valid a", a_dinv, r_cdv);
    chk("model core_din_valid b", b_dinv, r_cdv);
    chk("model tx_valid a", a_txv, txv);
    chk("model tx_valid b", b_txv, txv);
    if (txv) begin
      if (r_lbsend) begin em = r_lb; el = r_lb; end
      else begin
        em = 8'(r_word >> (8 * (r_left - 1)));
        el = 8'(r_word >> (8 * (BPW - r_left)));
      end
      chk("model tx_data msb", a_txd, em);
      chk("model tx_data lsb", b_txd, el);
    end
    chk("model fifo_level a", a_lvl, r_q.size());
    chk("model fifo_level b", b_lvl, r_q.size());
    chk("model drop_count a", a_cnt, r_cnt);
    chk("model drop_count b", b_cnt, r_cnt);
    chk("model led a", a_led, {r_lbmode, txv, r_full, r_ovf});
    chk("model led b", b_led, {r_lbmode, txv, r_full, r_ovf});
  endtask

  // Inputs change only after the falling edge; outputs are checked there too.
  task automatic tick();
    if (a_txv === 1'b1 && tx_ready) got.push_back(a_txd);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [DW-1:0] wordn(input int i);
    logic [3:0] n;
    n = 4'(i + 1);
    return {n, 4'h0, n, 4'h1, n, 4'h2, n, 4'h3};
  endfunction

  task automatic chk_got(input string nm, input logic [7:0] exp[$]);
    chk({nm, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s byte%0d", nm, i), got[i], exp[i]);
  endtask

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        dv;
    logic [31:0] dw;
    logic        cdv;
    logic [7:0]  cd;
    logic        txv;
    logic [7:0]  tx_m;
    logic [7:0]  tx_l;
  } vec_t;

  vec_t vec[16];

  initial begin
    logic [7:0] exp_b[$];

    vec[0]  = '{1'b1, 8'h3C, 1'b1, 32'hA1B2C3D4, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h00};
    vec[1]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'hA1, 8'hD4};
    vec[2]  = '{1'b1, 8'h5A, 1'b0, 32'h0,        1'b1, 8'h5A, 1'b1, 8'hB2, 8'hC3};
    vec[3]  = '{1'b1, 8'h96, 1'b0, 32'h0,        1'b1, 8'h96, 1'b1, 8'hC3, 8'hB2};
    vec[4]  = '{1'b0, 8'h07, 1'b0, 32'h0,        1'b0, 8'h07, 1'b1, 8'hD4, 8'hA1};
    vec[5]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 32'h11223344, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 32'h55667788, 1'b0, 8'h00, 1'b1, 8'h11, 8'h44};
    vec[8]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h22, 8'h33};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h33, 8'h22};
    vec[10] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h44, 8'h11};
    vec[11] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h55, 8'h88};
    vec[12] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h66, 8'h77};
    vec[13] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h77, 8'h66};
    vec[14] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 8'h88, 8'h55};
    vec[15] = '{1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 8'h00, 8'h00};

    rst = 1'b1; loopback = 1'b0; clear_status = 1'b0; rx_valid = 1'b0; rx_data = '0;
    core_dout_valid = 1'b0; core_dout = '0; tx_ready = 1'b0;
    tick(); tick();
    chk("reset tx_valid", a_txv, 1'b0);
    chk("reset tx_data", a_txd, 8'h00);
    chk("reset core_din", a_din, 8'h00);
    chk("reset core_din_valid", a_dinv, 1'b0);
    chk("reset fifo_level", a_lvl, 0);
    chk("reset drop_count", a_cnt, 0);
    chk("reset led", a_led, 4'h0);
    rst = 1'b0;
    tick();

    // latency, byte order, back-to-back words, RX echo
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_valid = vec[i].rxv; rx_data = vec[i].rxd;
      core_dout_valid = vec[i].dv; core_dout = vec[i].dw;
      tick();
      chk($sformatf("vec%0d core_din_valid", i), a_dinv, vec[i].cdv);
      chk($sformatf("vec%0d core_din", i), a_din, vec[i].cd);
      chk($sformatf("vec%0d tx_valid", i), a_txv, vec[i].txv);
      if (vec[i].txv) begin
        chk($sformatf("vec%0d tx_data msb", i), a_txd, vec[i].tx_m);
        chk($sformatf("vec%0d tx_data lsb", i), b_txd, vec[i].tx_l);
      end
    end
    rx_valid = 1'b0; core_dout_valid = 1'b0;

    // overflow: first word sits in the serializer, four fill the FIFO, two drop
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      core_dout_valid = 1'b1; core_dout = wordn(i);
      tick();
    end
    core_dout_valid = 1'b0;
    tick();
    chk("ovf fifo_level", a_lvl, DEPTH);
    chk("ovf drop_count", a_cnt, 2);
    chk("ovf led", a_led, 4'b0111);
    clear_status = 1'b1;
    tick();
    chk("clear drop_count", a_cnt, 0);
    chk("clear led ovf/full", a_led[1:0], 2'b10);
    core_dout_valid = 1'b1; core_dout = 32'hDEAD0000;
    tick();
    chk("clear+drop drop_count", a_cnt, 1);
    chk("clear+drop led ovf", a_led[0], 1'b1);
    clear_status = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("drop_count saturates", a_cnt, CMAX);
    core_dout_valid = 1'b0; clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clear2 drop_count", a_cnt, 0);
    chk("clear2 led ovf", a_led[0], 1'b0);

    // drain with a 3-cycle stall on the third byte of the first word
    got.delete();
    tx_ready = 1'b1;
    tick(); tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d tx_valid", i), a_txv, 1'b1);
      chk($sformatf("stall%0d tx_data", i), a_txd, 8'h12);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    exp_b.delete();
    for (int w = 0; w < 5; w++)
      for (int b = 0; b < 4; b++) exp_b.push_back({4'(w + 1), 4'(b)});
    chk_got("drain", exp_b);
    chk("drain fifo_level", a_lvl, 0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clear full led", a_led[1], 1'b0);

    // loopback echo, then a dropped byte under back-pressure
    got.delete();
    loopback = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    chk("lb core_din_valid", a_dinv, 1'b0);
    chk("lb led3", a_led[3], 1'b1);
    rx_valid = 1'b0;
    tick(); tick();
    rx_valid = 1'b1; rx_data = 8'hAA;
    tick();
    chk("lb core_din_valid 2", a_dinv, 1'b0);
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    exp_b = '{8'h55, 8'hAA};
    chk_got("loopback", exp_b);
    got.delete();
    tx_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h11;
    tick();
    rx_valid = 1'b0;
    tick(); tick();
    rx_valid = 1'b1; rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    chk("lb drop_count", a_cnt, 1);
    chk("lb led ovf", a_led[0], 1'b1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    exp_b = '{8'h11};
    chk_got("lb backpressure", exp_b);

    // loopback raised while a word is in flight
    loopback = 1'b0; got.delete();
    core_dout_valid = 1'b1; core_dout = 32'hCAFEBABE;
    tick();
    core_dout_valid = 1'b0;
    tick(); tick();
    loopback = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    loopback = 1'b0;
    exp_b = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h77};
    chk_got("midword loopback", exp_b);

    // reset in the middle of a word
    core_dout_valid = 1'b1; core_dout = 32'h0BADF00D;
    tick();
    core_dout_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; rx_data = 8'h99;
    tick();
    chk("midrst tx_valid", a_txv, 1'b0);
    chk("midrst tx_data", a_txd, 8'h00);
    chk("midrst core_din", a_din, 8'h00);
    chk("midrst fifo_level", a_lvl, 0);
    chk("midrst drop_count", a_cnt, 0);
    chk("midrst led", a_led, 4'h0);
    rst = 1'b0;
    tick();

    // random traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      core_dout_valid = ($urandom_range(0, (c < 1500) ? 2 : 7) == 0);
      core_dout = $urandom();
      tx_ready = ($urandom_range(0, 9) < 7);
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data = 8'($urandom());
      if ($urandom_range(0, 39) == 0) loopback = ~loopback;
      clear_status = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
